spi_flash_responder: RTL

//  SPI target (mode 0, MSB first) emulating the command subset of a serial NOR flash that the jtag2spi bridge issues.

---
 rtl/spi_flash_responder.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 target emulating a small serial NOR flash.
// Ports: clkin/rstn, SPI pins sclk/nss/mosi/miso/miso_oe, write bus, wel.
module spi_flash_responder #(
  parameter int          ADDR_W   = 8,
  parameter logic [23:0] JEDEC_ID = 24'hEF4015,
  parameter int          SYNC_STG = 2
) (
  input  logic              clkin,
  input  logic              rstn,
  input  logic              sclk,
  input  logic              nss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wel
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_STAT = 3'd5;
  localparam logic [2:0] S_ID   = 3'd6;
  localparam logic [2:0] S_IGN  = 3'd7;

  logic [SYNC_STG-1:0] sclk_q;
  logic [SYNC_STG-1:0] nss_q;
  logic [SYNC_STG-1:0] mosi_q;
  logic                sclk_h;
  logic                nss_h;

  // nss chain resets low so a select already held low at reset
  // release never looks like a falling edge.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      sclk_q <= '0;
      nss_q  <= '0;
      mosi_q <= '0;
      sclk_h <= 1'b0;
      nss_h  <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STG-2:0], sclk};
      nss_q  <= {nss_q[SYNC_STG-2:0], nss};
      mosi_q <= {mosi_q[SYNC_STG-2:0], mosi};
      sclk_h <= sclk_q[SYNC_STG-1];
      nss_h  <= nss_q[SYNC_STG-1];
    end
  end

  logic sclk_s, nss_s, mosi_s;
  logic sclk_r, sclk_f, nss_r, nss_f;

  assign sclk_s = sclk_q[SYNC_STG-1];
  assign nss_s  = nss_q[SYNC_STG-1];
  assign mosi_s = mosi_q[SYNC_STG-1];
  assign sclk_r = sclk_s & ~sclk_h;
  assign sclk_f = ~sclk_s & sclk_h;
  assign nss_r  = nss_s & ~nss_h;
  assign nss_f  = ~nss_s & nss_h;

  logic [2:0]        state;
  logic [2:0]        bcnt;
  logic [6:0]        rx;
  logic [7:0]        sh;
  logic [7:0]        tx;
  logic [1:0]        acnt;
  logic [1:0]        idcnt;
  logic              is_read;
  logic              prog_seen;
  logic              oe;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        mem [DEPTH];

  logic              act;
  logic              done;
  logic              mem_we;
  logic [7:0]        rxb;
  logic [ADDR_W-1:0] addr_sh;
  logic [ADDR_W-1:0] addr_inc;

  assign act      = ~nss_s & (state != S_IDLE);
  assign rxb      = {rx, mosi_s};
  assign done     = act & sclk_r & (bcnt == 3'd7);
  assign mem_we   = done & (state == S_WR) & wel;
  // Address bytes shift in MSB first; only the low ADDR_W bits survive.
  assign addr_sh  = ADDR_W'({addr, rxb});
  assign addr_inc = addr + 1'b1;

  assign miso    = sh[7];
  assign miso_oe = oe;

  always_ff @(posedge clkin) begin
    if (mem_we) mem[addr] <= rxb;
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      bcnt      <= '0;
      rx        <= '0;
      sh        <= '0;
      tx        <= '0;
      acnt      <= '0;
      idcnt     <= '0;
      is_read   <= 1'b0;
      prog_seen <= 1'b0;
      oe        <= 1'b0;
      addr      <= '0;
      wel       <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (nss_r) begin
        state     <= S_IDLE;
        oe        <= 1'b0;
        sh        <= '0;
        bcnt      <= '0;
        prog_seen <= 1'b0;
        if (prog_seen) wel <= 1'b0;
      end else if (nss_f) begin
        state <= S_CMD;
        oe    <= 1'b1;
        sh    <= '0;
        tx    <= '0;
        bcnt  <= '0;
        acnt  <= '0;
        idcnt <= '0;
      end else if (act) begin
        if (sclk_r) begin
          rx   <= rxb[6:0];
          bcnt <= bcnt + 3'd1;
        end
        // The fall right after a byte boundary presents the freshly
        // loaded byte; every other fall advances the current one.
        if (sclk_f) begin
          if (bcnt == 3'd0) sh <= tx;
          else sh <= {sh[6:0], 1'b0};
        end
        if (done) begin
          unique case (state)
            S_CMD: begin
              tx <= '0;
              unique case (1'b1)
                rxb == 8'h06: begin
                  wel   <= 1'b1;
                  state <= S_IGN;
                end
                rxb == 8'h04: begin
                  wel   <= 1'b0;
                  state <= S_IGN;
                end
                rxb == 8'h03: begin
                  is_read <= 1'b1;
                  state   <= S_ADDR;
                end
                rxb == 8'h02: begin
                  is_read <= 1'b0;
                  state   <= S_ADDR;
                end
                rxb == 8'h05: begin
                  tx    <= {6'b0, wel, 1'b0};
                  state <= S_STAT;
                end
                rxb == 8'h9F: begin
                  tx    <= JEDEC_ID[23:16];
                  idcnt <= 2'd1;
                  state <= S_ID;
                end
                default: state <= S_IGN;
              endcase
            end
            S_ADDR: begin
              addr <= addr_sh;
              acnt <= acnt + 2'd1;
              if (acnt == 2'd2) begin
                if (is_read) begin
                  tx    <= mem[addr_sh];
                  state <= S_RD;
                end else begin
                  state <= S_WR;
                end
              end
            end
            S_RD: begin
              addr <= addr_inc;
              tx   <= mem[addr_inc];
            end
            S_WR: begin
              prog_seen <= 1'b1;
              if (wel) begin
                addr    <= addr_inc;
                wr_stb  <= 1'b1;
                wr_addr <= addr;
                wr_data <= rxb;
              end
            end
            S_STAT: tx <= {6'b0, wel, 1'b0};
            S_ID: begin
              unique case (idcnt)
                2'd1: begin
                  tx    <= JEDEC_ID[15:8];
                  idcnt <= 2'd2;
                end
                2'd2: begin
                  tx    <= JEDEC_ID[7:0];
                  idcnt <= 2'd3;
                end
                default: tx <= '0;
              endcase
            end
            S_IGN:  tx <= '0;
            S_IDLE: tx <= '0;
          endcase
        end
      end
    end
  end
endmodule
